// File: rtl/laser_ctrl_pkg.sv
// rtl/laser_ctrl_pkg.sv - shared types and defaults for the laser gate path
package laser_ctrl_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        GATE,
        HOLDOFF
    } gate_state_t;

endpackage

// File: rtl/trig_sync_edge.sv
// rtl/trig_sync_edge.sv - trig_in synchronizer with rising-edge pulse
module trig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_in,
    output logic trig_rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // History resets high so a trigger already high at reset release is not an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trig_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign trig_rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/digitizer_gate_generator.sv
// rtl/digitizer_gate_generator.sv - trigger-to-gate delay/width/holdoff sequencer with shot statistics
module digitizer_gate_generator
    import laser_ctrl_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = 2,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              clear_stats,
    input  logic              trig_in,
    input  logic [CNT_W-1:0]  delay_cycles,
    input  logic [CNT_W-1:0]  width_cycles,
    input  logic [CNT_W-1:0]  holdoff_cycles,
    output logic              gate,
    output logic              busy,
    output logic [STAT_W-1:0] shot_count,
    output logic [STAT_W-1:0] missed_count
);

    localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    logic              trig_rise;
    gate_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  width_q, holdoff_q;
    logic [CNT_W-1:0]  w_src, h_src;
    gate_state_t       after_gate_state, after_delay_state;
    logic [CNT_W-1:0]  after_gate_cnt, after_delay_cnt;
    logic              accept, missed;
    logic              gate_q, busy_q;
    logic [STAT_W-1:0] shot_q, missed_q;

    trig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_trig_sync_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .trig_in   (trig_in),
        .trig_rise (trig_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        missed  = 1'b0;

        // In IDLE the live config is about to be latched, so use it directly
        w_src = (state_q == IDLE) ? width_cycles   : width_q;
        h_src = (state_q == IDLE) ? holdoff_cycles : holdoff_q;

        if (h_src != '0) begin
            after_gate_state = HOLDOFF;
            after_gate_cnt   = h_src - CNT_ONE;
        end else begin
            after_gate_state = IDLE;
            after_gate_cnt   = '0;
        end

        // Zero width skips the gate phase entirely
        if (w_src != '0) begin
            after_delay_state = GATE;
            after_delay_cnt   = w_src - CNT_ONE;
        end else begin
            after_delay_state = after_gate_state;
            after_delay_cnt   = after_gate_cnt;
        end

        case (state_q)
            IDLE: begin
                if (trig_rise) begin
                    if (enable) begin
                        accept = 1'b1;
                        if (delay_cycles != '0) begin
                            state_d = DELAY;
                            cnt_d   = delay_cycles - CNT_ONE;
                        end else begin
                            state_d = after_delay_state;
                            cnt_d   = after_delay_cnt;
                        end
                    end else begin
                        missed = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (cnt_q == '0) begin
                    state_d = after_delay_state;
                    cnt_d   = after_delay_cnt;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GATE: begin
                if (cnt_q == '0) begin
                    state_d = after_gate_state;
                    cnt_d   = after_gate_cnt;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && trig_rise) begin
            missed = 1'b1;
        end

        // Disarming aborts the shot immediately without holdoff
        if (!enable) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            width_q   <= '0;
            holdoff_q <= '0;
            gate_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gate_q  <= (state_d == GATE);
            busy_q  <= (state_d != IDLE);
            if (accept) begin
                width_q   <= width_cycles;
                holdoff_q <= holdoff_cycles;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shot_q   <= '0;
            missed_q <= '0;
        end else if (clear_stats) begin
            shot_q   <= '0;
            missed_q <= '0;
        end else begin
            if (accept && shot_q != '1) begin
                shot_q <= shot_q + STAT_ONE;
            end
            if (missed && missed_q != '1) begin
                missed_q <= missed_q + STAT_ONE;
            end
        end
    end

    assign gate         = gate_q;
    assign busy         = busy_q;
    assign shot_count   = shot_q;
    assign missed_count = missed_q;

endmodule

// File: tb/tb_digitizer_gate_generator.sv
// tb/tb_digitizer_gate_generator.sv - self-checking bench for digitizer_gate_generator
module tb_digitizer_gate_generator;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b1;
    logic        clear_stats = 1'b0;
    logic        trig_in = 1'b0;
    logic [31:0] delay_cycles = '0;
    logic [31:0] width_cycles = '0;
    logic [31:0] holdoff_cycles = '0;
    logic        gate, busy, gate4, busy4;
    logic [15:0] shot_count, missed_count;
    logic [3:0]  shot_count4, missed_count4;

    digitizer_gate_generator #(.CNT_W(32), .SYNC_STAGES(S), .STAT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear_stats(clear_stats),
        .trig_in(trig_in), .delay_cycles(delay_cycles), .width_cycles(width_cycles),
        .holdoff_cycles(holdoff_cycles), .gate(gate), .busy(busy),
        .shot_count(shot_count), .missed_count(missed_count)
    );

    digitizer_gate_generator #(.CNT_W(32), .SYNC_STAGES(S), .STAT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear_stats(clear_stats),
        .trig_in(trig_in), .delay_cycles(delay_cycles), .width_cycles(width_cycles),
        .holdoff_cycles(holdoff_cycles), .gate(gate4), .busy(busy4),
        .shot_count(shot_count4), .missed_count(missed_count4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int gate_hi = 0;

    // Reference model: a shot is a time interval computed from its acceptance edge
    bit     samples[$];
    int     n = 0;
    bit     m_active = 0;
    longint m_start = 0, m_end = 0;
    longint m_d = 0, m_w = 0;
    int     m_shots = 0, m_missed = 0;
    bit     exp_gate = 0, exp_busy = 0;

    typedef struct {
        bit trig;
        bit gate;
        bit busy;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit samp(input int i);
        if (i < 0) return 1'b1;
        return samples[i];
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_edge();
        bit rise, idle;
        if (!rst_n) begin
            samples.delete();
            n = 0;
            m_active = 0;
            m_shots = 0;
            m_missed = 0;
        end else begin
            samples.push_back(trig_in);
            rise = samp(n - S) & ~samp(n - S - 1);
            idle = !m_active || (n - 1 >= m_end);
            if (!enable) m_active = 0;
            if (rise) begin
                if (idle && enable) begin
                    m_active = 1;
                    m_start  = n;
                    m_d      = delay_cycles;
                    m_w      = width_cycles;
                    m_end    = n + longint'(delay_cycles) + longint'(width_cycles)
                             + longint'(holdoff_cycles);
                    m_shots++;
                end else begin
                    m_missed++;
                end
            end
            if (clear_stats) begin
                m_shots = 0;
                m_missed = 0;
            end
            n++;
        end
        exp_busy = m_active && (n - 1 < m_end);
        exp_gate = m_active && (n - 1 >= m_start + m_d) && (n - 1 < m_start + m_d + m_w);
    endtask

    task automatic compare();
        if (gate) gate_hi++;
        chk("gate", gate, exp_gate);
        chk("busy", busy, exp_busy);
        chk("shot_count", shot_count, sat(m_shots, 65535));
        chk("missed_count", missed_count, sat(m_missed, 65535));
        chk("gate_w4", gate4, exp_gate);
        chk("shot_count_w4", shot_count4, sat(m_shots, 15));
        chk("missed_count_w4", missed_count4, sat(m_missed, 15));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic idle_cycles(input int k);
        repeat (k) tick();
    endtask

    task automatic pulse(input int hi, input int lo);
        trig_in = 1'b1;
        idle_cycles(hi);
        trig_in = 1'b0;
        idle_cycles(lo);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
    endtask

    task automatic set_cfg(input int d, input int w, input int h);
        delay_cycles = d;
        width_cycles = w;
        holdoff_cycles = h;
    endtask

    task automatic clear_pulse();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        gate_hi = 0;
    endtask

    vec_t tbl[16];

    initial begin
        tbl[0]  = '{0, 0, 0};  tbl[1]  = '{0, 0, 0};
        tbl[2]  = '{0, 0, 0};  tbl[3]  = '{1, 0, 0};
        tbl[4]  = '{1, 0, 0};  tbl[5]  = '{1, 0, 1};
        tbl[6]  = '{1, 0, 1};  tbl[7]  = '{0, 0, 1};
        tbl[8]  = '{0, 1, 1};  tbl[9]  = '{0, 1, 1};
        tbl[10] = '{0, 1, 1};  tbl[11] = '{0, 1, 1};
        tbl[12] = '{0, 0, 1};  tbl[13] = '{0, 0, 1};
        tbl[14] = '{0, 0, 0};  tbl[15] = '{0, 0, 0};

        // Reset state and test 1: D=3 W=4 H=2 from a table
        set_cfg(3, 4, 2);
        do_reset();
        chk("reset_gate", gate, 0);
        chk("reset_busy", busy, 0);
        for (int i = 0; i < 16; i++) begin
            trig_in = tbl[i].trig;
            tick();
            chk($sformatf("t1_gate[%0d]", i), gate, tbl[i].gate);
            chk($sformatf("t1_busy[%0d]", i), busy, tbl[i].busy);
        end
        chk("t1_shots", shot_count, 1);

        // Test 2: D=0 W=1 H=0, triggers four cycles apart
        set_cfg(0, 1, 0);
        clear_pulse();
        pulse(2, 2);
        pulse(2, 8);
        chk("t2_gate_cycles", gate_hi, 2);
        chk("t2_shots", shot_count, 2);
        chk("t2_missed", missed_count, 0);

        // Test 3: second rise during GATE is missed
        set_cfg(2, 10, 5);
        clear_pulse();
        pulse(2, 6);
        pulse(2, 25);
        chk("t3_gate_cycles", gate_hi, 10);
        chk("t3_shots", shot_count, 1);
        chk("t3_missed", missed_count, 1);

        // Test 4: trig_in high across reset release is not an event
        set_cfg(1, 2, 1);
        trig_in = 1'b1;
        do_reset();
        gate_hi = 0;
        idle_cycles(8);
        chk("t4_gate_cycles", gate_hi, 0);
        chk("t4_shots", shot_count, 0);
        chk("t4_missed", missed_count, 0);
        trig_in = 1'b0;
        idle_cycles(4);
        pulse(2, 20);
        chk("t4_gate_cycles2", gate_hi, 2);
        chk("t4_shots2", shot_count, 1);

        // Test 5: width change mid-shot, then abort via enable
        set_cfg(1, 6, 3);
        clear_pulse();
        pulse(2, 2);
        chk("t5_gate_on", gate, 1);
        width_cycles = 2;
        idle_cycles(3);
        chk("t5_gate_old_width", gate, 1);
        enable = 1'b0;
        tick();
        chk("t5_abort_gate", gate, 0);
        chk("t5_abort_busy", busy, 0);
        enable = 1'b1;
        gate_hi = 0;
        pulse(2, 20);
        chk("t5_new_width", gate_hi, 2);
        chk("t5_shots", shot_count, 2);

        // Test 6: saturation in the 4-bit instance, clear beats simultaneous accept
        set_cfg(0, 1, 0);
        clear_pulse();
        for (int i = 0; i < 17; i++) pulse(2, 2);
        idle_cycles(4);
        chk("t6_sat_w4", shot_count4, 15);
        chk("t6_count_w16", shot_count, 17);
        trig_in = 1'b1;
        idle_cycles(2);
        trig_in = 1'b0;
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        chk("t6_clear_gate", gate, 1);
        chk("t6_clear_w16", shot_count, 0);
        chk("t6_clear_w4", shot_count4, 0);
        idle_cycles(4);

        // Randomized traffic against the interval model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) trig_in = ~trig_in;
            enable = ($urandom_range(0, 29) != 0);
            clear_stats = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 9) == 0)
                set_cfg($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
            tick();
        end
        clear_stats = 1'b0;
        enable = 1'b1;
        idle_cycles(20);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
